// File: rtl/ddr_burst_wr_ctrl.sv
// ddr_burst_wr_ctrl: drains the 256b pixel FIFO into DDR as fixed AXI4 write bursts.
// Optional bresp error counter is enabled by defining BURST_WR_BRESP_CHK_EN.
module ddr_burst_wr_ctrl #(
  parameter int          ADDR_WIDTH  = 28,
  parameter int          DATA_WIDTH  = 256,
  parameter int          LEVEL_WIDTH = 11,
  parameter int          BURST_LEN   = 16,
  parameter int unsigned ADDR_BASE   = 0,
  parameter int unsigned FRAME_BYTES = 4147200
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  input  logic                   frame_start,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_level,
  output logic [ADDR_WIDTH-1:0]  m_awaddr,
  output logic [7:0]             m_awlen,
  output logic                   m_awvalid,
  input  logic                   m_awready,
  output logic [DATA_WIDTH-1:0]  m_wdata,
  output logic                   m_wvalid,
  output logic                   m_wlast,
  input  logic                   m_wready,
  input  logic [1:0]             m_bresp,
  input  logic                   m_bvalid,
  output logic                   m_bready,
  output logic                   busy,
  output logic [15:0]            err_cnt
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int unsigned BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;

  localparam logic [ADDR_WIDTH-1:0] BASE_A =
    ADDR_WIDTH'(ADDR_BASE);
  localparam logic [ADDR_WIDTH-1:0] STEP_A =
    ADDR_WIDTH'(BURST_BYTES);
  localparam logic [ADDR_WIDTH:0] END_A =
    {1'b0, BASE_A} + (ADDR_WIDTH+1)'(FRAME_BYTES);
  localparam logic [7:0] AWLEN_C = 8'(BURST_LEN - 1);
  localparam logic [CW-1:0] LEN_C = CW'(BURST_LEN);
  localparam logic [CW-1:0] LAST_C = CW'(BURST_LEN - 1);
  localparam logic [LEVEL_WIDTH-1:0] LVL_C =
    LEVEL_WIDTH'(BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [7:0]              r_awlen;
  logic                    r_awvalid;
  logic                    r_bready;
  logic                    r_fs_pend;
  logic [CW-1:0]           r_rd_cnt;
  logic [CW-1:0]           r_beat;
  logic                    r_wdone;
  logic                    r_inflight;
  logic [1:0]              r_cnt;
  logic [DATA_WIDTH-1:0]   r_buf0;
  logic [DATA_WIDTH-1:0]   r_buf1;

  logic                    w_wvalid;
  logic                    w_pop;
  logic                    w_last_pop;
  logic                    w_act;
  logic [2:0]              w_occ;
  logic                    w_room;
  logic                    w_rd_en;
  logic                    w_fs;
  logic                    w_start;
  logic                    w_b_hs;
  logic [ADDR_WIDTH:0]     w_adv_x;
  logic                    w_wrap;
  logic [ADDR_WIDTH-1:0]   w_adv;
  logic [ADDR_WIDTH-1:0]   w_next_addr;
  logic [ADDR_WIDTH-1:0]   w_idle_addr;

  assign w_wvalid = (r_cnt != 2'd0);
  assign w_pop = w_wvalid & m_wready;
  assign w_last_pop = w_pop & (r_beat == LAST_C);
  assign w_act = (r_state == S_ADDR) | (r_state == S_DATA);

  // Occupancy after this cycle's pop, counting the read still in flight.
  assign w_occ = {1'b0, r_cnt} - {2'b00, w_pop}
               + {2'b00, r_inflight};
  assign w_room = (w_occ < 3'd2);

  assign w_rd_en = w_act & (r_rd_cnt < LEN_C)
                 & ~fifo_rd_empty & w_room;

  assign w_fs = r_fs_pend | frame_start;
  assign w_start = (fifo_rd_level >= LVL_C) & ~fifo_rd_empty;
  assign w_b_hs = (r_state == S_RESP) & m_bvalid;

  assign w_adv_x = {1'b0, r_addr} + {1'b0, STEP_A};
  assign w_wrap = (w_adv_x == END_A);
  assign w_adv = w_adv_x[ADDR_WIDTH-1:0];
  assign w_next_addr = (w_fs | w_wrap) ? BASE_A : w_adv;
  assign w_idle_addr = w_fs ? BASE_A : r_addr;

  assign fifo_rd_en = w_rd_en;
  assign m_awaddr = r_awaddr;
  assign m_awlen = r_awlen;
  assign m_awvalid = r_awvalid;
  assign m_wdata = r_buf0;
  assign m_wvalid = w_wvalid;
  assign m_wlast = w_wvalid & (r_beat == LAST_C);
  assign m_bready = r_bready;
  assign busy = (r_state != S_IDLE);

  // Burst sequencing, address pointer and frame restart handling.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_state <= S_IDLE;
      r_addr <= BASE_A;
      r_awaddr <= '0;
      r_awlen <= '0;
      r_awvalid <= 1'b0;
      r_bready <= 1'b0;
      r_fs_pend <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_fs) begin
            r_addr <= BASE_A;
            r_fs_pend <= 1'b0;
          end
          if (w_start) begin
            r_state <= S_ADDR;
            r_awvalid <= 1'b1;
            r_awaddr <= w_idle_addr;
            r_awlen <= AWLEN_C;
          end
        end
        S_ADDR: begin
          if (frame_start) r_fs_pend <= 1'b1;
          if (m_awready) begin
            r_awvalid <= 1'b0;
            if (r_wdone | w_last_pop) begin
              r_state <= S_RESP;
              r_bready <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (frame_start) r_fs_pend <= 1'b1;
          if (w_last_pop) begin
            r_state <= S_RESP;
            r_bready <= 1'b1;
          end
        end
        S_RESP: begin
          if (m_bvalid) begin
            r_state <= S_IDLE;
            r_bready <= 1'b0;
            r_addr <= w_next_addr;
            r_fs_pend <= 1'b0;
          end else if (frame_start) begin
            r_fs_pend <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Per-burst read and beat counters, cleared when the response lands.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_rd_cnt <= '0;
      r_beat <= '0;
      r_wdone <= 1'b0;
    end else if (w_b_hs) begin
      r_rd_cnt <= '0;
      r_beat <= '0;
      r_wdone <= 1'b0;
    end else begin
      if (w_rd_en) r_rd_cnt <= r_rd_cnt + CW'(1);
      if (w_pop) r_beat <= r_beat + CW'(1);
      if (w_last_pop) r_wdone <= 1'b1;
    end
  end

  // Two-entry skid buffer fed one cycle after each FIFO read.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_inflight <= 1'b0;
      r_cnt <= 2'd0;
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      r_inflight <= w_rd_en;
      unique case ({r_inflight, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_buf0 <= fifo_rd_data;
          else r_buf1 <= fifo_rd_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd2) begin
            r_buf0 <= r_buf1;
            r_buf1 <= fifo_rd_data;
          end else begin
            r_buf0 <= fifo_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BURST_WR_BRESP_CHK_EN
  logic [15:0] r_err;

  // Saturating count of non-OKAY write responses.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_err <= '0;
    end else if (m_bvalid & r_bready & (m_bresp != 2'b00)
                 & (r_err != 16'hFFFF)) begin
      r_err <= r_err + 16'd1;
    end
  end

  assign err_cnt = r_err;
`else
  logic w_unused_bresp;

  assign w_unused_bresp = ^m_bresp;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ddr_burst_wr_ctrl.sv
// tb_ddr_burst_wr_ctrl: FIFO/AXI-slave model with a scoreboard for the
// burst writer, run with an 8 KiB frame so address wrap is reachable.
module tb_ddr_burst_wr_ctrl;
  localparam int AW = 28;
  localparam int DW = 256;
  localparam int LW = 11;
  localparam int BL = 16;
  localparam int FB = 8192;
  localparam int BB = BL * DW / 8;
  localparam int NB = FB / BB;
  localparam int BASE = 0;

  logic rd_clk = 1'b0;
  logic rd_rst = 1'b1;
  logic frame_start = 1'b0;
  logic fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic fifo_rd_empty = 1'b1;
  logic [LW-1:0] fifo_rd_level = '0;
  logic [AW-1:0] m_awaddr;
  logic [7:0] m_awlen;
  logic m_awvalid;
  logic m_awready = 1'b0;
  logic [DW-1:0] m_wdata;
  logic m_wvalid;
  logic m_wlast;
  logic m_wready = 1'b0;
  logic [1:0] m_bresp = 2'b00;
  logic m_bvalid = 1'b0;
  logic m_bready;
  logic busy;
  logic [15:0] err_cnt;

  always #5 rd_clk = ~rd_clk;

  ddr_burst_wr_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEVEL_WIDTH(LW),
    .BURST_LEN(BL), .ADDR_BASE(BASE), .FRAME_BYTES(FB)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .frame_start(frame_start),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty), .fifo_rd_level(fifo_rd_level),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid),
    .m_awready(m_awready), .m_wdata(m_wdata), .m_wvalid(m_wvalid),
    .m_wlast(m_wlast), .m_wready(m_wready), .m_bresp(m_bresp),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .busy(busy),
    .err_cnt(err_cnt)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] pend;
  bit pend_v;
  int seq = 0;
  int cyc_n = 0;

  // reference model state
  int idx, beat, wbeats, reads, bdone, first_cyc, err_exp;
  longint exp_aw;
  bit fs_pend_m, inflight_m, b_owed, tp_chk;
  bit pw_stall, pa_stall;
  logic [DW-1:0] pw_data;
  logic pw_last;
  logic [AW-1:0] pa_addr;
  longint aw_log[$];

  typedef struct {
    int lvl;
    bit aw;
  } vec_t;
  vec_t vt[3];

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push();
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom();
    w[31:0] = seq;
    seq++;
    fq.push_back(w);
    sb.push_back(w);
    fifo_rd_empty = 1'b0;
    fifo_rd_level = LW'(fq.size());
  endtask

  task automatic model_reset();
    fq.delete();
    sb.delete();
    pend_v = 0;
    fifo_rd_empty = 1'b1;
    fifo_rd_level = '0;
    idx = 0; beat = 0; wbeats = 0; reads = 0; err_exp = 0;
    fs_pend_m = 0; inflight_m = 0; b_owed = 0;
    pw_stall = 0; pa_stall = 0;
  endtask

  task automatic chk_zero(input string tag);
    #1;
    chk({tag, "_aw"}, {m_awvalid, m_awaddr, m_awlen}, 0);
    chk({tag, "_w"}, {m_wvalid, m_wlast, |m_wdata}, 0);
    chk({tag, "_misc"}, {fifo_rd_en, m_bready, err_cnt}, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Observe one settled cycle and advance the model.
  task automatic mon();
    logic [DW-1:0] e;
    if (rd_rst) return;
    if (fifo_rd_en) begin
      chk("rd_when_empty", fifo_rd_empty, 0);
      reads++;
      if (reads > BL) chk("rd_per_burst_max", reads, BL);
      if (fq.size() > 0) begin
        pend = fq.pop_front();
        pend_v = 1;
      end
    end
    if (pa_stall)
      chk("aw_hold", {m_awvalid, m_awaddr == pa_addr}, 2'b11);
    if (m_awvalid && !inflight_m) begin
      inflight_m = 1;
      if (fs_pend_m) begin
        idx = 0;
        fs_pend_m = 0;
      end
      exp_aw = BASE + idx * BB;
    end
    if (m_awvalid && m_awready) begin
      chk("awaddr", m_awaddr, exp_aw);
      chk("awlen", m_awlen, BL - 1);
      aw_log.push_back(longint'(m_awaddr));
      idx = (idx + 1) % NB;
    end
    pa_stall = m_awvalid && !m_awready;
    pa_addr = m_awaddr;
    if (pw_stall)
      chk("w_hold", {m_wvalid, m_wlast == pw_last,
                     m_wdata == pw_data}, 3'b111);
    if (m_wvalid && m_wready) begin
      e = (sb.size() > 0) ? sb.pop_front() : 'x;
      chk_w("wdata", m_wdata, e);
      chk("wlast", m_wlast, beat == BL - 1);
      if (beat == 0) first_cyc = cyc_n;
      if (beat == BL - 1 && tp_chk)
        chk("throughput", cyc_n - first_cyc, BL - 1);
      beat = (beat + 1) % BL;
      wbeats++;
      if (beat == 0) b_owed = 1;
    end
    pw_stall = m_wvalid && !m_wready;
    pw_data = m_wdata;
    pw_last = m_wlast;
    if (frame_start) fs_pend_m = 1;
    if (m_bvalid && m_bready) begin
      chk("beats_per_burst", wbeats, BL);
      chk("reads_per_burst", reads, BL);
      wbeats = 0;
      reads = 0;
      b_owed = 0;
      inflight_m = 0;
      bdone++;
`ifdef BURST_WR_BRESP_CHK_EN
      if (m_bresp != 2'b00) err_exp++;
`endif
    end
  endtask

  task automatic cyc();
    #1;
    mon();
    @(posedge rd_clk);
    #1;
    cyc_n++;
    if (pend_v) begin
      fifo_rd_data = pend;
      pend_v = 0;
    end
    fifo_rd_empty = (fq.size() == 0);
    fifo_rd_level = LW'(fq.size());
  endtask

  task automatic do_reset();
    rd_rst = 1'b1;
    m_awready = 0; m_wready = 0; m_bvalid = 0; frame_start = 0;
    repeat (2) @(posedge rd_clk);
    #1;
    rd_rst = 1'b0;
    model_reset();
    chk_zero("reset");
  endtask

  // wmode 0: all ready, 1: wready toggles, 2: random handshakes.
  task automatic run(input int nb, input int wmode, input int fs_beat,
                     input int rst_beat, input logic [1:0] bresp);
    int target;
    int budget;
    bit fs_done;
    target = bdone + nb;
    budget = 400 * nb;
    fs_done = 0;
    tp_chk = (wmode == 0);
    while (bdone < target && budget > 0) begin
      budget--;
      if (rst_beat >= 0 && wbeats == rst_beat) begin
        m_wready = 0; m_awready = 0; m_bvalid = 0;
        rd_rst = 1'b1;
        cyc();
        rd_rst = 1'b0;
        model_reset();
        chk_zero("mid_rst");
        return;
      end
      if (fq.size() < 64 && (wmode == 0 || $urandom_range(0, 2) != 0))
        push();
      case (wmode)
        0: m_wready = 1'b1;
        1: m_wready = cyc_n[0];
        default: m_wready = 1'($urandom_range(0, 1));
      endcase
      m_awready = (wmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      m_bvalid = b_owed && (wmode == 0 || $urandom_range(0, 1) == 1);
      m_bresp = bresp;
      frame_start = (fs_beat >= 0 && !fs_done && wbeats == fs_beat);
      if (frame_start) fs_done = 1;
      cyc();
    end
    chk("run_timeout", bdone, target);
    m_wready = 0; m_awready = 0; m_bvalid = 0; frame_start = 0;
    tp_chk = 0;
  endtask

  initial begin
    int base_n;
    vt[0] = '{lvl: 0, aw: 1'b0};
    vt[1] = '{lvl: 15, aw: 1'b0};
    vt[2] = '{lvl: 16, aw: 1'b1};
    bdone = 0;
    model_reset();
    do_reset();

    // level threshold vectors
    for (int i = 0; i < 3; i++) begin
      while (fq.size() < vt[i].lvl) push();
      m_awready = 0;
      repeat (3) cyc();
      chk("thr_awvalid", m_awvalid, vt[i].aw);
      chk("thr_busy", busy, vt[i].aw);
      if (vt[i].aw) begin
        chk("thr_awaddr", m_awaddr, BASE);
        chk("thr_awlen", m_awlen, BL - 1);
      end
    end

    run(1, 0, -1, -1, 2'b00);
    run(1, 1, -1, -1, 2'b00);
    chk("addr_b1", aw_log[aw_log.size()-1], BASE + BB);

    // frame_start during the burst at 0x400
    run(1, 1, 5, -1, 2'b00);
    chk("addr_b2", aw_log[aw_log.size()-1], BASE + 2 * BB);
    run(1, 2, -1, -1, 2'b00);
    chk("fs_restart", aw_log[aw_log.size()-1], BASE);

    // reset in the middle of a burst, then restart from base
    run(1, 2, -1, -1, 2'b00);
    run(1, 0, -1, 7, 2'b00);
    run(1, 1, -1, -1, 2'b00);
    chk("rst_restart", aw_log[aw_log.size()-1], BASE);

    // full frame plus one burst
    do_reset();
    base_n = aw_log.size();
    run(NB + 1, 2, -1, -1, 2'b00);
    if (aw_log.size() >= base_n + NB + 1) begin
      chk("frame_1", aw_log[base_n+1], BASE + 'h200);
      chk("frame_15", aw_log[base_n+15], BASE + 'h1E00);
      chk("frame_wrap", aw_log[base_n+NB], BASE);
    end else begin
      chk("frame_aw_count", aw_log.size() - base_n, NB + 1);
    end

    // error responses
    run(3, 2, -1, -1, 2'b10);
`ifdef BURST_WR_BRESP_CHK_EN
    chk("err_cnt", err_cnt, 3);
`else
    chk("err_cnt", err_cnt, 0);
`endif
    chk("err_model", err_cnt, err_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
